// File: rtl/matrix_frame_capture.sv
// Receive-side monitor for the Matrix256 serial link: deserializes latched words,
// decodes row patterns and integrates four brightness passes into a 16x16x2-bit frame.
module matrix_frame_capture #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sclk,
   input  logic        serial_data,
   input  logic        rclk,
   input  logic        clear,
   output logic [15:0] row_pattern,
   output logic [3:0]  row_sel,
   output logic        row_valid,
   output logic        frame_done,
   output logic        onehot_err,
   input  logic [3:0]  rd_row,
   input  logic [3:0]  rd_col,
   output logic [1:0]  rd_pix
);

   // Clock chains carry one extra flop so edges are seen from the last two stages
   localparam int NS = SYNC_STAGES + 1;

   logic [NS-1:0]          sclkSync_q;
   logic [NS-1:0]          rclkSync_q;
   logic [SYNC_STAGES-1:0] dataSync_q;
   logic [SYNC_STAGES-1:0] clearSync_q;

   logic        sclkRise;
   logic        rclkRise;
   logic        sdi;
   logic        clearN;

   logic [31:0] sr_q, sr_d;
   logic [31:0] lat_q, lat_d;
   logic        latNew_q, latNew_d;

   logic [15:0] anode;
   logic [15:0] cathLow;
   logic        oneHot;
   logic [3:0]  rowIdx;
   logic [15:0][1:0] newAcc;

   logic [15:0] rowPattern_q;
   logic [3:0]  rowSel_q;
   logic        rowValid_q;
   logic        frameDone_q;
   logic        onehotErr_q;
   logic [1:0]  rdPix_q;

   logic [15:0][1:0] acc_q   [16];
   logic [15:0][1:0] frame_q [16];
   logic [1:0]       pc_q    [16];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclkSync_q  <= '0;
         rclkSync_q  <= '0;
         dataSync_q  <= '0;
         clearSync_q <= '0;
      end else begin
         sclkSync_q  <= {sclkSync_q[NS-2:0], sclk};
         rclkSync_q  <= {rclkSync_q[NS-2:0], rclk};
         dataSync_q  <= {dataSync_q[SYNC_STAGES-2:0], serial_data};
         clearSync_q <= {clearSync_q[SYNC_STAGES-2:0], clear};
      end
   end

   assign sclkRise = sclkSync_q[NS-2] & ~sclkSync_q[NS-1];
   assign rclkRise = rclkSync_q[NS-2] & ~rclkSync_q[NS-1];
   assign sdi      = dataSync_q[SYNC_STAGES-1];
   assign clearN   = clearSync_q[SYNC_STAGES-1];

   // Latch always takes the register value from before this cycle's shift or clear
   always_comb begin
      sr_d     = sr_q;
      lat_d    = lat_q;
      latNew_d = rclkRise;
      if (!clearN) begin
         sr_d = '0;
      end else if (sclkRise) begin
         sr_d = {sr_q[30:0], sdi};
      end
      if (rclkRise) begin
         lat_d = sr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q     <= '0;
         lat_q    <= '0;
         latNew_q <= 1'b0;
      end else begin
         sr_q     <= sr_d;
         lat_q    <= lat_d;
         latNew_q <= latNew_d;
      end
   end

   // Cathodes are active-low; a valid word has exactly one row driven low
   always_comb begin
      anode  = lat_q[31:16];
      rowIdx = '0;
      for (int r = 0; r < 16; r++) begin
         cathLow[r] = ~lat_q[15-r];
      end
      oneHot = (cathLow != 16'd0) && ((cathLow & (cathLow - 16'd1)) == 16'd0);
      for (int r = 0; r < 16; r++) begin
         if (cathLow[r]) begin
            rowIdx = 4'(r);
         end
      end
      for (int x = 0; x < 16; x++) begin
         if (acc_q[rowIdx][x] == 2'd3) begin
            newAcc[x] = 2'd3;
         end else begin
            newAcc[x] = acc_q[rowIdx][x] + {1'b0, anode[x]};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rowPattern_q <= '0;
         rowSel_q     <= '0;
         rowValid_q   <= 1'b0;
         frameDone_q  <= 1'b0;
         onehotErr_q  <= 1'b0;
         rdPix_q      <= '0;
         for (int r = 0; r < 16; r++) begin
            acc_q[r]   <= '0;
            frame_q[r] <= '0;
            pc_q[r]    <= '0;
         end
      end else begin
         rowValid_q  <= 1'b0;
         frameDone_q <= 1'b0;
         rdPix_q     <= frame_q[rd_row][rd_col];
         if (latNew_q) begin
            if (oneHot) begin
               rowSel_q     <= rowIdx;
               rowPattern_q <= anode;
               rowValid_q   <= 1'b1;
               if (pc_q[rowIdx] == 2'd3) begin
                  frame_q[rowIdx] <= newAcc;
                  acc_q[rowIdx]   <= '0;
                  pc_q[rowIdx]    <= 2'd0;
                  frameDone_q     <= (rowIdx == 4'd15);
               end else begin
                  acc_q[rowIdx] <= newAcc;
                  pc_q[rowIdx]  <= pc_q[rowIdx] + 2'd1;
               end
            end else begin
               onehotErr_q <= 1'b1;
            end
         end
      end
   end

   assign row_pattern = rowPattern_q;
   assign row_sel     = rowSel_q;
   assign row_valid   = rowValid_q;
   assign frame_done  = frameDone_q;
   assign onehot_err  = onehotErr_q;
   assign rd_pix      = rdPix_q;

endmodule
